// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built on one full-adder cell.
// The operands are shifted through the cell LSB first, one bit per clock, and the
// carry is held in a register between cycles. A result takes WIDTH cycles after
// the operands are accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   a/b/cin are valid
//   in_ready   ready to accept operands (IDLE and not in reset; combinational)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum/cout hold a completed result
//   out_ready  downstream accepts the result
//   sum        registered result, a+b+cin mod 2^WIDTH
//   cout       registered carry-out of the MSB
//   busy       high while the serial add is running
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // cnt has to hold WIDTH (its value after the last bit), so it never wraps
    localparam int unsigned   CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic fa_sum;
    logic fa_carry;
    logic last_bit;

    logic accept;
    logic step;
    logic finish;
    logic release_res;

    // Single full-adder cell fed by the low bits of the shift registers
    always_comb begin
        fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        fa_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last_bit = (cnt == LAST_BIT);
        // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the first sum bit
        acc_shift = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and datapath control decode
    always_comb begin
        in_ready    = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: in_ready = !rst;
            RUN: begin
                step   = 1'b1;
                finish = last_bit;
            end
            DONE: release_res = out_valid && out_ready;
            default: ;
        endcase
        accept = in_valid && in_ready;
    end

    // Operand shift registers, carry, bit counter and partial-sum accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_shift;
            carry <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Visible result: updated only when the last bit completes
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (finish) begin
            sum       <= acc_shift;
            cout      <= fa_carry;
            out_valid <= 1'b1;
        end else if (release_res) begin
            out_valid <= 1'b0;
        end
    end

    // busy mirrors RUN as a flop: set on accept, cleared with the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (accept) begin
            busy <= 1'b1;
        end else if (finish) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios and a
// 1-bit instance for the full-adder truth table.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation to completion on the 8-bit instance and return the result
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         output logic [7:0] s, output logic c, output int lat);
        int n;
        n        = 0;
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        s = sum;
        c = cout;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({out_valid, sum, cout, busy} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ov=%b sum=%h cout=%b busy=%b, expected all zero",
                     out_valid, sum, cout, busy);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready_idle: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        int n;
        int busy_cnt;
        bit partial;
        n        = 0;
        busy_cnt = 0;
        partial  = 1'b0;
        a        = 8'h3C;
        b        = 8'h05;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 8'hFF;
        b        = 8'hFF;
        while (!out_valid && n < 50) begin
            if (busy) busy_cnt++;
            if (sum !== 8'h00) partial = 1'b1;
            tick();
            n++;
        end
        tests_run++;
        if (n != 8) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d expected 8", n);
        end
        tests_run++;
        if (busy_cnt != 8) begin
            tests_failed++;
            $display("FAIL basic_busy_cycles: got %0d expected 8", busy_cnt);
        end
        tests_run++;
        if (partial) begin
            tests_failed++;
            $display("FAIL basic_partial_visible: sum changed during RUN, expected 00");
        end
        tests_run++;
        if ({cout, sum} !== 9'h041) begin
            tests_failed++;
            $display("FAIL basic_sum: got cout=%b sum=%h expected cout=0 sum=41", cout, sum);
        end
        tests_run++;
        if ({busy, in_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_done_flags: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_release: got ov=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic       c;
        int         lat;
        do_op(8'hFF, 8'h01, 1'b0, s, c, lat);
        tests_run++;
        if ({c, s} !== 9'h100 || lat != 8) begin
            tests_failed++;
            $display("FAIL ovf_ff_01: got cout=%b sum=%h lat=%0d expected cout=1 sum=00 lat=8", c, s, lat);
        end
        do_op(8'hFF, 8'hFF, 1'b1, s, c, lat);
        tests_run++;
        if ({c, s} !== 9'h1FF || lat != 8) begin
            tests_failed++;
            $display("FAIL ovf_ff_ff_1: got cout=%b sum=%h lat=%0d expected cout=1 sum=ff lat=8", c, s, lat);
        end
    endtask

    task automatic test_backpressure();
        int n;
        n        = 0;
        a        = 8'h12;
        b        = 8'h34;
        cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        // Next operands stay pending through RUN and DONE
        a   = 8'h11;
        b   = 8'h22;
        cin = 1'b0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if ({cout, sum} !== 9'h047) begin
            tests_failed++;
            $display("FAIL bp_first_sum: got cout=%b sum=%h expected cout=0 sum=47", cout, sum);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 8'h47}) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got ov=%b in_ready=%b sum=%h expected 1 0 47",
                         i, out_valid, in_ready, sum);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bp_release: got ov=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_pending_accept: got busy=%b expected 1", busy);
        end
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if ({cout, sum} !== 9'h033 || n != 8) begin
            tests_failed++;
            $display("FAIL bp_second_sum: got cout=%b sum=%h lat=%0d expected cout=0 sum=33 lat=8",
                     cout, sum, n);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic       c;
        int         lat;
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, sum, cout, busy, in_ready} !== 12'h001) begin
            tests_failed++;
            $display("FAIL midreset_state: got ov=%b sum=%h cout=%b busy=%b in_ready=%b expected 0 00 0 0 1",
                     out_valid, sum, cout, busy, in_ready);
        end
        do_op(8'h01, 8'h01, 1'b1, s, c, lat);
        tests_run++;
        if ({c, s} !== 9'h003 || lat != 8) begin
            tests_failed++;
            $display("FAIL midreset_after: got cout=%b sum=%h lat=%0d expected cout=0 sum=03 lat=8", c, s, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ca;
        logic [7:0] cb;
        logic       cc;
        logic [8:0] exp;
        int         n;
        ca        = 8'($urandom);
        cb        = 8'($urandom);
        cc        = 1'($urandom);
        a         = ca;
        b         = cb;
        cin       = cc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready);
            end
            exp = {1'b0, ca} + {1'b0, cb} + {8'h00, cc};
            tick();
            ca  = 8'($urandom);
            cb  = 8'($urandom);
            cc  = 1'($urandom);
            a   = ca;
            b   = cb;
            cin = cc;
            n   = 0;
            while (!out_valid && n < 50) begin
                tick();
                n++;
            end
            tests_run++;
            if ({cout, sum} !== exp || n != 8) begin
                tests_failed++;
                $display("FAIL stream_%0d: got cout=%b sum=%h lat=%0d expected cout=%b sum=%h lat=8",
                         i, cout, sum, n, exp[8], exp[7:0]);
            end
            if (i == 99) in_valid = 1'b0;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_width1();
        logic [1:0] tab [0:7];
        logic [2:0] v;
        int         n;
        tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v         = 3'(i);
            a1        = v[2];
            b1        = v[1];
            cin1      = v[0];
            in_valid1 = 1'b1;
            tests_run++;
            if (in_ready1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL w1_ready_%0d: got %b expected 1", i, in_ready1);
            end
            tick();
            in_valid1 = 1'b0;
            tests_run++;
            if (busy1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL w1_busy_%0d: got %b expected 1", i, busy1);
            end
            n = 0;
            while (!out_valid1 && n < 20) begin
                tick();
                n++;
            end
            tests_run++;
            if ({cout1, sum1} !== tab[i] || n != 1) begin
                tests_failed++;
                $display("FAIL w1_fa_%0d: got cout=%b sum=%b lat=%0d expected cout=%b sum=%b lat=1",
                         i, cout1, sum1, n, tab[i][1], tab[i][0]);
            end
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
